// File: rtl/tmr_pkg.sv
// Shared definitions for the loadable down-timer: state encoding and default width.
package tmr_pkg;

    localparam int unsigned DEFAULT_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1
    } tmr_state_e;

endpackage

// File: rtl/prog_down_timer_if.sv
// Load handshake and status bundle between a timer client (master) and the timer (slave).
interface prog_down_timer_if
    import tmr_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             load_valid;
    logic [WIDTH-1:0] load_val;
    logic             auto_reload;
    logic             pause;
    logic             stop;
    logic             load_ready;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             tc;

    modport master (
        output load_valid, load_val, auto_reload, pause, stop,
        input  load_ready, q, busy, tc
    );

    modport slave (
        input  load_valid, load_val, auto_reload, pause, stop,
        output load_ready, q, busy, tc
    );

endinterface

// File: rtl/prog_down_timer.sv
// Loadable down-counter: decrements once per enabled clock, pulses tc on expiry,
// optionally reloading its period for a periodic tick.
module prog_down_timer
    import tmr_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    prog_down_timer_if.slave   tmr
);

    tmr_state_e       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             reload_en_q, reload_en_d;
    logic             tc_q, tc_d;
    logic             busy_q;
    logic             load_ready;

    assign load_ready = (state_q == ST_IDLE) && !rst;

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        reload_d    = reload_q;
        reload_en_d = reload_en_q;
        tc_d        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tmr.load_valid && load_ready) begin
                    if (tmr.load_val != '0) begin
                        q_d         = tmr.load_val;
                        reload_d    = tmr.load_val;
                        reload_en_d = tmr.auto_reload;
                        state_d     = ST_RUN;
                    end else begin
                        // A zero load expires immediately without ever entering RUN.
                        tc_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (tmr.stop) begin
                    q_d         = '0;
                    reload_en_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (!tmr.pause) begin
                    if (q_q != WIDTH'(1)) begin
                        q_d = q_q - WIDTH'(1);
                    end else begin
                        tc_d = 1'b1;
                        if (reload_en_q) begin
                            q_d = reload_q;
                        end else begin
                            q_d     = '0;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            q_q         <= '0;
            reload_q    <= '0;
            reload_en_q <= 1'b0;
            tc_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            reload_q    <= reload_d;
            reload_en_q <= reload_en_d;
            tc_q        <= tc_d;
            busy_q      <= (state_d == ST_RUN);
        end
    end

    assign tmr.load_ready = load_ready;
    assign tmr.q          = q_q;
    assign tmr.busy       = busy_q;
    assign tmr.tc         = tc_q;

endmodule
